// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// iteration count and the signed-overflow boundary value.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Two's complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // The remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign o_qbit    = ~w_diff[WIDTH];
    assign o_rem     = o_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/reg_32.sv
// Plain 32-bit register with load enable and synchronous clear.
module reg_32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            o_q <= 32'd0;
        end else if (i_enable) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit
// with a fixed 33-cycle start-to-ready latency.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t      r_state;
    logic [5:0]  r_count;
    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_qm1;
    logic [32:0] r_mcand;
    logic [31:0] r_divisor;
    logic        r_negQuot;
    logic        r_divZero;
    logic        r_divOvf;
    logic        r_exception;
    logic        r_rdy;

    logic        w_start;
    logic        w_lastStep;
    logic        w_enterDone;
    logic [32:0] w_boothSum;
    logic [63:0] w_product;
    logic        w_multOvf;
    logic [31:0] w_nextRem;
    logic        w_qBit;
    logic [31:0] w_final;
    logic        w_finalExc;

    assign w_start     = ctrl_MULT | ctrl_DIV;
    assign w_lastStep  = (r_count == 6'(ITER_COUNT));
    assign w_enterDone = ((r_state == MULT) || (r_state == DIV)) && w_lastStep && !w_start;

    // The accumulator carries a guard bit so an INT_MIN multiplicand cannot overflow it.
    always_comb begin
        w_boothSum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_boothSum = r_acc + r_mcand;
            2'b10:   w_boothSum = r_acc - r_mcand;
            default: w_boothSum = r_acc;
        endcase
    end

    assign w_product = {r_acc[31:0], r_q};
    assign w_multOvf = !((&w_product[63:31]) || !(|w_product[63:31]));

    // The low accumulator bits double as the division remainder.
    div_step #(.WIDTH(32)) u_divStep (
        .i_rem     (r_acc[31:0]),
        .i_bit     (r_q[31]),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_qbit    (w_qBit)
    );

    always_comb begin
        w_final    = 32'd0;
        w_finalExc = 1'b0;
        if (r_state == MULT) begin
            w_final    = w_product[31:0];
            w_finalExc = w_multOvf;
        end else if (r_divZero) begin
            w_final    = 32'd0;
            w_finalExc = 1'b1;
        end else if (r_divOvf) begin
            w_final    = INT_MIN;
            w_finalExc = 1'b1;
        end else begin
            w_final    = r_negQuot ? (~r_q + 32'd1) : r_q;
            w_finalExc = 1'b0;
        end
    end

    // A start pulse in any state restarts; the cycle after the last step commits the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= 6'd0;
            r_acc       <= 33'd0;
            r_q         <= 32'd0;
            r_qm1       <= 1'b0;
            r_mcand     <= 33'd0;
            r_divisor   <= 32'd0;
            r_negQuot   <= 1'b0;
            r_divZero   <= 1'b0;
            r_divOvf    <= 1'b0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= w_enterDone;
            if (w_start) begin
                r_count <= 6'd0;
                r_acc   <= 33'd0;
                r_qm1   <= 1'b0;
                if (ctrl_MULT) begin
                    r_state <= MULT;
                    r_mcand <= {data_operandA[31], data_operandA};
                    r_q     <= data_operandB;
                end else begin
                    r_state   <= DIV;
                    r_q       <= magnitude(data_operandA);
                    r_divisor <= magnitude(data_operandB);
                    r_negQuot <= data_operandA[31] ^ data_operandB[31];
                    r_divZero <= (data_operandB == 32'd0);
                    r_divOvf  <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
                end
            end else begin
                case (r_state)
                    MULT: begin
                        if (w_lastStep) begin
                            r_state     <= DONE;
                            r_exception <= w_finalExc;
                        end else begin
                            {r_acc, r_q, r_qm1} <= {w_boothSum[32], w_boothSum, r_q};
                            r_count             <= r_count + 6'd1;
                        end
                    end
                    DIV: begin
                        if (w_lastStep) begin
                            r_state     <= DONE;
                            r_exception <= w_finalExc;
                        end else begin
                            r_acc   <= {1'b0, w_nextRem};
                            r_q     <= {r_q[30:0], w_qBit};
                            r_count <= r_count + 6'd1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    reg_32 u_resultReg (
        .clock    (clock),
        .reset    (reset),
        .i_enable (w_enterDone),
        .i_d      (w_final),
        .o_q      (data_result)
    );

    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int testsRun    = 0;
    int testsFailed = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model straight from the arithmetic definition.
    function automatic void model(input logic isMult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        longint p;
        int     q;
        if (isMult) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = $signed(a) / $signed(b);
            res = q;
            exc = 1'b0;
        end
    endfunction

    // Pulse a start, scramble operands afterwards, measure latency and strobe width.
    task automatic run_op(input logic isMult, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc,
                          output int latency, output int rdyWidth);
        @(negedge clock);
        ctrl_MULT     = isMult;
        ctrl_DIV      = !isMult;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        latency = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                latency = n;
                break;
            end
        end
        res = data_result;
        exc = data_exception;
        @(posedge clock);
        #1;
        rdyWidth = data_resultRDY ? 2 : 1;
    endtask

    task automatic test_reset();
        int strobes = 0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        testsRun++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got result=%h exc=%b rdy=%b, want all zero",
                     data_result, data_exception, data_resultRDY);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) strobes++;
        end
        testsRun++;
        if (strobes !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_beats_start: got %0d strobes, want 0", strobes);
        end
    endtask

    task automatic test_directed();
        logic        isMult [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
        logic [31:0] opA    [8] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                    32'd100, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] opB    [8] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd2,
                                    32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] expRes [8] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'hFFFF_FFFD,
                                    32'hFFFF_FFF6, 32'h0, 32'h8000_0000, 32'd1};
        logic        expExc [8] = '{0, 1, 0, 0, 0, 1, 1, 0};
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          width;
        for (int i = 0; i < 8; i++) begin
            run_op(isMult[i], opA[i], opB[i], res, exc, lat, width);
            testsRun++;
            if (res !== expRes[i] || exc !== expExc[i]) begin
                testsFailed++;
                $display("[TB] FAIL directed_%0d: got result=%h exc=%b, want result=%h exc=%b",
                         i, res, exc, expRes[i], expExc[i]);
            end
            testsRun++;
            if (lat !== 33 || width !== 1) begin
                testsFailed++;
                $display("[TB] FAIL directed_timing_%0d: got latency=%0d width=%0d, want 33 and 1",
                         i, lat, width);
            end
        end
    endtask

    task automatic test_random();
        logic        isMult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic [31:0] expRes;
        logic        expExc;
        int          lat;
        int          width;
        for (int i = 0; i < 24; i++) begin
            isMult = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) a = 32'($signed(16'($urandom)));
            if ($urandom_range(0, 2) == 0) b = 32'($signed(8'($urandom)));
            model(isMult, a, b, expRes, expExc);
            run_op(isMult, a, b, res, exc, lat, width);
            testsRun++;
            if (res !== expRes || exc !== expExc || lat !== 33) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d (%s %h,%h): got %h/%b lat %0d, want %h/%b lat 33",
                         i, isMult ? "mul" : "div", a, b, res, exc, lat, expRes, expExc);
            end
        end
    endtask

    task automatic test_restart();
        int          strobes = 0;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          width;
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        for (int n = 0; n < 9; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) strobes++;
        end
        run_op(1'b0, 32'd20, 32'd5, res, exc, lat, width);
        testsRun++;
        if (res !== 32'd4 || exc !== 1'b0 || lat !== 33 || strobes !== 0) begin
            testsFailed++;
            $display("[TB] FAIL restart: got %h/%b lat %0d early strobes %0d, want 4/0 lat 33 strobes 0",
                     res, exc, lat, strobes);
        end
    endtask

    task automatic test_reset_mid();
        int          strobes = 0;
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          width;
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd1000;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        testsRun++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_outputs: got result=%h exc=%b rdy=%b, want all zero",
                     data_result, data_exception, data_resultRDY);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) strobes++;
        end
        testsRun++;
        if (strobes !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_strobe: got %0d strobes, want 0", strobes);
        end
        run_op(1'b1, 32'd2, 32'd2, res, exc, lat, width);
        testsRun++;
        if (res !== 32'd4 || exc !== 1'b0 || lat !== 33) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_recover: got %h/%b lat %0d, want 4/0 lat 33", res, exc, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          width;
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, exc, lat, width);
        testsRun++;
        if (res !== 32'd1 || exc !== 1'b0 || lat !== 33) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_a: got %h/%b lat %0d, want 1/0 lat 33", res, exc, lat);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, res, exc, lat, width);
        testsRun++;
        if (res !== 32'd0 || exc !== 1'b0 || lat !== 33) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_b: got %h/%b lat %0d, want 0/0 lat 33", res, exc, lat);
        end
        repeat (3) @(posedge clock);
        #1;
        testsRun++;
        if (data_result !== 32'd0 || data_resultRDY !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL result_hold: got result=%h rdy=%b, want 0 held with rdy 0",
                     data_result, data_resultRDY);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit for the processor's execute stage. It sits directly upstream of the register file write port and produces the 32-bit word that a register captures on write-back. It accepts a one-cycle start pulse, iterates for a fixed 32 steps (radix-2 Booth multiply or restoring divide), then presents the result with a one-cycle ready strobe and an exception flag. The pipeline stalls on `data_resultRDY`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is supported and verified.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply.
- `ctrl_DIV`  in  1  one-cycle start pulse for divide.
- `data_operandA`  in  32  multiplicand or dividend (two's complement); sampled only in the start cycle.
- `data_operandB`  in  32  multiplier or divisor (two's complement); sampled only in the start cycle.
- `data_result`  out  32  low 32 bits of the product, or the quotient.
- `data_exception`  out  1  multiply overflow, divide-by-zero, or INT_MIN/−1.
- `data_resultRDY`  out  1  high for exactly one cycle when `data_result` and `data_exception` are valid.

## Operation
- States:
  - IDLE: no operation in progress.
  - MULT: multiply iterations in progress.
  - DIV: divide iterations in progress.
  - DONE: result is being presented.
- Transitions:
  - IDLE→MULT on `ctrl_MULT`; IDLE→DIV on `ctrl_DIV`.
  - MULT/DIV→DONE after iteration count 31.
  - DONE→IDLE unconditionally.
- Start:
  - On the start edge, operands are captured into internal registers and the iteration counter is cleared.
  - If `ctrl_MULT` and `ctrl_DIV` are high in the same cycle, `ctrl_MULT` wins.
- Restart: a start pulse in any state, including MULT, DIV or DONE, aborts the current operation and restarts with the new operands. The aborted operation never raises `data_resultRDY`.
- Multiply:
  - Radix-2 Booth over a 65-bit {acc, Q, q−1} register, one step per cycle.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:31] is not all-0 and not all-1.
- Divide:
  - Restoring divide on the operand magnitudes, one quotient bit per cycle.
  - The quotient is negated if the operand signs differ, which gives truncation toward zero.
  - Divisor = 0: result 0, exception 1. Latency is still the full count.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
  - The remainder is not output.
- Outputs:
  - `data_result` and `data_exception` are registered and hold their value from DONE until the next DONE or reset.
  - `data_resultRDY` is registered and high only in DONE.
- Reset values: state IDLE, counter 0, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
- Reset mid-operation: the operation is discarded and no ready strobe is produced.
- Reset wins over a simultaneous start pulse.

## Timing
- Start pulse sampled at edge k. Iterations occur on edges k+1 … k+32. DONE is entered at edge k+33, so `data_resultRDY` is high during the cycle after edge k+33.
- Fixed latency of 33 cycles from start edge to ready, identical for every operation type and every exception case.
- Ports other than the operands are never sampled combinationally into outputs; there is no combinational path from input to output.
- Operand changes after the start cycle have no effect.

## Structure
- Shared package `multdiv_pkg`:
  - state encoding constants IDLE/MULT/DIV/DONE;
  - `ITER_COUNT` = 32;
  - `INT_MIN` = 32'h80000000.
- One sub-module, `div_step`: a combinational single restoring step. It takes the remainder, the dividend bit and the divisor, and returns the next remainder and the quotient bit.
- The Booth step stays inline in the datapath.
- The output result register is built from an existing `reg_32` instance:
  - enable = entering DONE;
  - synchronous clear driven by `reset`.

## Test plan
- MULT 7 × −3 → `data_resultRDY` high exactly 33 cycles after the pulse, result 0xFFFFFFEB, exception 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x80000000 × 1 → result 0x80000000, exception 0.
- DIV −7 / 2 → result 0xFFFFFFFD (−3), exception 0. DIV 100 / −10 → result 0xFFFFFFF6, exception 0.
- DIV 5 / 0 → result 0, exception 1, ready still at 33 cycles. DIV 0x80000000 / −1 → result 0x80000000, exception 1.
- MULT 3 × 4 started, then DIV 20 / 5 pulsed at cycle 10 → a single ready strobe 33 cycles after the DIV pulse, result 4. No strobe appears for the MULT.
- MULT pulsed, then `reset` asserted at cycle 15 for one cycle → all outputs 0, no ready strobe within 40 cycles. A following MULT 2 × 2 → result 4 at 33 cycles.
